tick_divider_bank: RTL and testbench

// - Bank of programmable tick dividers in NumGroups generate-groups. Group k holds 2**k channels.
// - Flat channel index c = 2**k - 1 + l. Channel c period = BasePeriod*(c+1) cycles.
// - Counter widths are derived per generate iteration; the block exercises nested-loop parameter propagation.
// - Ticks are latched as pending events and drained one at a time over a valid/ready event port.

---
 rtl/tick_bank_pkg.sv | 29 ++
 rtl/tick_divider.sv | 43 ++++
 rtl/tick_divider_bank.sv | 133 +++++++++++++
 tb/tb_tick_divider_bank.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_bank_pkg.sv
// Shared helpers for the tick divider bank: channel indexing,
// per-channel period and counter width, and the event id type.
package tick_bank_pkg;

  localparam int unsigned MaxIdW = 5;

  typedef logic [MaxIdW-1:0] evt_id_t;

  function automatic int unsigned chan_idx(
    input int unsigned k,
    input int unsigned l
  );
    return (2 ** k) - 1 + l;
  endfunction

  function automatic int unsigned chan_period(
    input int unsigned base,
    input int unsigned c
  );
    return base * (c + 1);
  endfunction

  function automatic int unsigned cnt_width(
    input int unsigned p
  );
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// One programmable divider: counts enabled cycles 0..Period-1.
// Ports: clk_i, rst_ni, clear_i, en_i in; tick_o pulses at Period-1.
module tick_divider #(
  parameter int unsigned Period   = 1,
  parameter int unsigned CntWidth = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CntWidth-1:0] Last =
    CntWidth'(Period - 1);

  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;
  logic                at_last;

  assign at_last = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Gated by reset so a period-1 channel stays quiet in reset.
  assign tick_o = rst_ni & en_i & at_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of tick dividers in NumGroups groups with a pending/overflow
// event queue drained over evt_valid_o/evt_ready_i (id lock on stall).
module tick_divider_bank
  import tick_bank_pkg::*;
#(
  parameter int unsigned NumGroups  = 3,
  parameter int unsigned BasePeriod = 1,
  localparam int unsigned NumChan =
    (2 ** NumGroups) - 1,
  localparam int unsigned IdWidth =
    (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumChan-1:0] en_i,
  input  logic               clear_i,
  output logic [NumChan-1:0] tick_o,
  output logic [NumGroups-1:0] group_tick_o,
  output logic               evt_valid_o,
  output logic [IdWidth-1:0] evt_id_o,
  input  logic               evt_ready_i,
  output logic [NumChan-1:0] overflow_o
);

  if (NumGroups < 1 || NumGroups > 5) begin : gen_bad_groups
    $error("NumGroups out of range 1..5");
  end

  if (BasePeriod < 1) begin : gen_bad_base
    $error("BasePeriod must be >= 1");
  end

  logic [NumChan-1:0] tick;
  logic [NumChan-1:0] pend_q;
  logic [NumChan-1:0] pend_d;
  logic [NumChan-1:0] ovf_q;
  logic [NumChan-1:0] ovf_d;
  logic [NumChan-1:0] pop;
  logic               lock_q;
  logic               lock_d;
  logic [IdWidth-1:0] lid_q;
  logic [IdWidth-1:0] lid_d;
  logic [IdWidth-1:0] low_id;
  logic [IdWidth-1:0] cur_id;
  logic               valid;

  for (genvar k = 0; k < NumGroups; k++) begin : gen_group
    localparam int unsigned GrpBase = chan_idx(k, 0);
    localparam int unsigned GrpSize = 2 ** k;

    for (genvar l = 0; l < GrpSize; l++) begin : gen_chan
      localparam int unsigned ChanIdx = chan_idx(k, l);
      localparam int unsigned ChanPeriod =
        chan_period(BasePeriod, ChanIdx);
      localparam int unsigned ChanCntW =
        cnt_width(ChanPeriod);

      if (ChanPeriod > 65536) begin : gen_bad_period
        $error("channel period exceeds 2**16");
      end

      tick_divider #(
        .Period  (ChanPeriod),
        .CntWidth(ChanCntW)
      ) u_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(clear_i),
        .en_i   (en_i[ChanIdx]),
        .tick_o (tick[ChanIdx])
      );
    end

    assign group_tick_o[k] = |tick[GrpBase +: GrpSize];
  end

  always_comb begin
    low_id = '0;
    for (int i = NumChan - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        low_id = IdWidth'(i);
      end
    end
  end

  assign valid  = |pend_q;
  assign cur_id = lock_q ? lid_q : low_id;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NumChan; i++) begin
      pop[i] = valid & evt_ready_i
             & (cur_id == IdWidth'(i));
    end
  end

  // A tick on a channel being popped re-arms it, not an overflow.
  always_comb begin
    pend_d = tick | (pend_q & ~pop);
    ovf_d  = ovf_q | (tick & pend_q & ~pop);
    lock_d = valid & ~evt_ready_i;
    lid_d  = cur_id;
    unique case (1'b1)
      clear_i: begin
        pend_d = '0;
        ovf_d  = '0;
        lock_d = 1'b0;
        lid_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      ovf_q  <= '0;
      lock_q <= 1'b0;
      lid_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      lock_q <= lock_d;
      lid_q  <= lid_d;
    end
  end

  assign tick_o      = tick;
  assign evt_valid_o = valid;
  assign evt_id_o    = cur_id;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_tick_divider_bank.sv
// Bench for tick_divider_bank: vector table, directed corner
// sequences and random stimulus against a count-based model.
module tb_tick_divider_bank;
  import tick_bank_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [6:0] en;
  logic       clr;
  logic       rdy;
  logic [6:0] tick;
  logic [2:0] grp;
  logic       vld;
  logic [2:0] id;
  logic [6:0] ovf;

  logic       rst2_n;
  logic [2:0] en2;
  logic       clr2;
  logic       rdy2;
  logic [2:0] tick2;
  logic [1:0] grp2;
  logic       vld2;
  logic [1:0] id2;
  logic [2:0] ovf2;

  int errors = 0;
  int checks = 0;

  logic [6:0] s_tick;
  logic [2:0] s_grp;
  logic       s_vld;
  logic [2:0] s_id;
  logic [6:0] s_ovf;

  int         ec[7];
  logic [6:0] m_pend;
  logic [6:0] m_ovf;
  bit         m_lock;
  int         m_lid;

  tick_divider_bank #(
    .NumGroups (3),
    .BasePeriod(1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .clear_i     (clr),
    .tick_o      (tick),
    .group_tick_o(grp),
    .evt_valid_o (vld),
    .evt_id_o    (id),
    .evt_ready_i (rdy),
    .overflow_o  (ovf)
  );

  tick_divider_bank #(
    .NumGroups (2),
    .BasePeriod(4)
  ) dut2 (
    .clk_i       (clk),
    .rst_ni      (rst2_n),
    .en_i        (en2),
    .clear_i     (clr2),
    .tick_o      (tick2),
    .group_tick_o(grp2),
    .evt_valid_o (vld2),
    .evt_id_o    (id2),
    .evt_ready_i (rdy2),
    .overflow_o  (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 7; c++) ec[c] = 0;
    m_pend = '0;
    m_ovf  = '0;
    m_lock = 1'b0;
    m_lid  = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en    = 7'h7f;
    clr   = 1'b0;
    rdy   = 1'b0;
    #2;
    chk("reset_outputs",
        32'({tick, grp, vld, id, ovf}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One cycle: compare against the model at negedge, then
  // advance the model with the inputs seen at the next edge.
  task automatic cycle();
    logic [6:0] et;
    logic [2:0] eg;
    logic       ev;
    int         eid;
    logic [6:0] pop;
    @(negedge clk);
    s_tick = tick;
    s_grp  = grp;
    s_vld  = vld;
    s_id   = id;
    s_ovf  = ovf;
    for (int c = 0; c < 7; c++)
      et[c] = en[c] && (ec[c] % (c + 1) == c);
    for (int k = 0; k < 3; k++) begin
      eg[k] = 1'b0;
      for (int c = (1 << k) - 1; c <= (2 << k) - 2; c++)
        eg[k] = eg[k] | et[c];
    end
    ev  = |m_pend;
    eid = 0;
    for (int c = 6; c >= 0; c--)
      if (m_pend[c]) eid = c;
    if (m_lock) eid = m_lid;
    chk("model",
        32'({tick, grp, vld, id, ovf}),
        32'({et, eg, ev, 3'(eid), m_ovf}));
    pop = '0;
    if (ev && rdy) pop[eid] = 1'b1;
    if (clr) begin
      model_reset();
    end else begin
      for (int c = 0; c < 7; c++) begin
        if (et[c]) begin
          if (m_pend[c] && !pop[c]) m_ovf[c] = 1'b1;
          m_pend[c] = 1'b1;
        end else if (pop[c]) begin
          m_pend[c] = 1'b0;
        end
        if (en[c]) ec[c]++;
      end
      m_lock = ev && !rdy;
      m_lid  = eid;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [6:0] en;
    logic       rdy;
    logic       e_t0;
    logic       e_t6;
    logic       e_g2;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [15:0] g2_mask;
    logic [15:0] t6_mask;
    rst_n  = 1'b0;
    en     = '0;
    clr    = 1'b0;
    rdy    = 1'b0;
    rst2_n = 1'b0;
    en2    = '0;
    clr2   = 1'b0;
    rdy2   = 1'b0;
    model_reset();

    g2_mask = 16'h55F0;
    t6_mask = 16'h4080;
    for (int i = 0; i < 14; i++) begin
      tbl[i].en   = 7'h7f;
      tbl[i].rdy  = 1'b1;
      tbl[i].e_t0 = 1'b1;
      tbl[i].e_t6 = t6_mask[i+1];
      tbl[i].e_g2 = g2_mask[i+1];
    end

    do_reset();
    for (int i = 0; i < 14; i++) begin
      en  = tbl[i].en;
      rdy = tbl[i].rdy;
      cycle();
      chk($sformatf("t0_c%0d", i + 1),
          32'(s_tick[0]), 32'(tbl[i].e_t0));
      chk($sformatf("t6_c%0d", i + 1),
          32'(s_tick[6]), 32'(tbl[i].e_t6));
      chk($sformatf("g2_c%0d", i + 1),
          32'(s_grp[2]), 32'(tbl[i].e_g2));
    end

    do_reset();
    en  = 7'b0000100;
    rdy = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      cycle();
      if (n == 3) chk("b_tick2_c3", 32'(s_tick[2]), 32'd1);
      if (n == 4) chk("b_evt_c4",
                      32'({s_vld, s_id}), 32'({1'b1, 3'd2}));
      if (n == 6) chk("b_ovf_c6", 32'(s_ovf), 32'd0);
      if (n == 7) chk("b_ovf_c7", 32'(s_ovf), 32'h04);
    end

    do_reset();
    rdy = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      en  = (n >= 6) ? 7'b0010010 : 7'b0010000;
      rdy = (n == 8);
      cycle();
      if (n == 8) chk("c_locked_id",
                      32'({s_vld, s_id}), 32'({1'b1, 3'd4}));
      if (n == 9) chk("c_next_id",
                      32'({s_vld, s_id}), 32'({1'b1, 3'd1}));
    end

    do_reset();
    en = 7'b0000100;
    for (int n = 1; n <= 7; n++) begin
      rdy = (n == 6);
      cycle();
      if (n == 6) chk("d_tick_pop", 32'(s_tick[2]), 32'd1);
      if (n == 7) begin
        chk("d_pend_kept",
            32'({s_vld, s_id}), 32'({1'b1, 3'd2}));
        chk("d_no_ovf", 32'(s_ovf), 32'd0);
      end
    end

    do_reset();
    en  = 7'b1100000;
    rdy = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      clr = (n == 14);
      cycle();
      if (n == 13) begin
        chk("e_ovf5", 32'(s_ovf[5]), 32'd1);
        chk("e_vld13", 32'(s_vld), 32'd1);
      end
      if (n == 14) chk("e_tick6_clr", 32'(s_tick[6]), 32'd1);
      if (n == 15) chk("e_cleared",
                       32'({s_vld, s_ovf}), 32'd0);
      if (n == 20) chk("e_tick6_c20", 32'(s_tick[6]), 32'd0);
      if (n == 21) chk("e_tick6_c21", 32'(s_tick[6]), 32'd1);
    end
    clr = 1'b0;

    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      en  = 7'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 39) == 0);
      cycle();
    end
    clr = 1'b0;

    @(posedge clk);
    #1;
    rst2_n = 1'b0;
    en2    = 3'b111;
    rdy2   = 1'b1;
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 3) chk("f_t0_c3", 32'(tick2[0]), 32'd0);
      if (n == 4) chk("f_t0_c4", 32'(tick2[0]), 32'd1);
      if (n == 8) chk("f_g1_c8", 32'(grp2[1]), 32'd1);
      @(posedge clk);
      #1;
    end
    #1;
    chk("f_vld_c9", 32'(vld2), 32'd1);
    rst2_n = 1'b0;
    #1;
    chk("f_async_rst",
        32'({tick2, grp2, vld2, id2, ovf2}), 32'd0);
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 3) chk("f_rel_c3", 32'(tick2[0]), 32'd0);
      if (n == 4) chk("f_rel_c4", 32'(tick2[0]), 32'd1);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
